mmc3_ext_mapper: RTL and testbench



---
 rtl/mmc3_ext_mapper.sv | 143 ++++++++++++++
 tb/tb_mmc3_ext_mapper.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mmc3_ext_mapper.sv
// mmc3_ext_mapper: MMC3-style PRG/CHR banking and scanline IRQ; define MMC3_EXT_EN for 1 KB CHR, R15 PRG and CPU-cycle IRQ
module mmc3_ext_mapper #(
  parameter int PRG_W = 6,
  parameter int CHR_W = 8,
  parameter int A12_LOW_MIN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_a14,
  input  logic             cpu_a13,
  input  logic             cpu_a0,
  input  logic             cpu_ce_n,
  input  logic             cpu_rw,
  input  logic             cpu_m2,
  input  logic [2:0]       ppu_addr,
  input  logic             mir_h,
  output logic             irq_n,
  output logic             ciram_a10,
  output logic             ram_ce_n,
  output logic             ram_we_n,
  output logic             prg_ce_n,
  output logic [PRG_W-1:0] prg_addr,
  output logic [CHR_W-1:0] chr_addr
);
`ifdef MMC3_EXT_EN
  localparam int NR = 16;
`else
  localparam int NR = 8;
`endif
  localparam int IW = $clog2(NR);
  localparam int LW = $clog2(A12_LOW_MIN + 1);
  localparam logic [7:0] rst_vals [16] = '{8'd0, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1,
                                           8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] r [NR];
  logic [IW-1:0] idx;
  logic prg_mod, chr_mod, mirroring, ram_ce_on, ram_we_off;
  logic [7:0] irq_latch, counter, next_cnt;
  logic reload, irq_en, pending, irq_mode;
  logic [1:0] presc;
  logic m2_s1, m2_s2, a12_s1, a12_s2;
  logic [LW-1:0] low_cnt;
  logic cap_ce_n, cap_a14, cap_a13, cap_a0, cap_rw;
  logic [7:0] cap_data;
  logic m2_fall, wr, a12_rise, clk_ev;
  logic [PRG_W-1:0] prg_l;
  logic [7:0] lo2k, c2k, c1k, chr8;
`ifdef MMC3_EXT_EN
  logic k1;
  assign prg_l = k1 ? r[15][PRG_W-1:0] : ~PRG_W'(1);
  assign c2k = k1 ? (ppu_addr[0] ? (ppu_addr[1] ? r[9] : r[8]) : lo2k)
                  : (lo2k & 8'hfe) | {7'd0, ppu_addr[0]};
`else
  assign irq_mode = 1'b0;
  assign prg_l = ~PRG_W'(1);
  assign c2k = (lo2k & 8'hfe) | {7'd0, ppu_addr[0]};
`endif
  assign m2_fall = m2_s2 & ~m2_s1;
  assign wr = m2_fall & ~cap_rw & ~cap_ce_n;
  // low_cnt counts clocks the synchronised A12 has been low, including the rise cycle
  assign a12_rise = a12_s1 & ~a12_s2 & (low_cnt >= LW'(A12_LOW_MIN));
  assign clk_ev = irq_mode ? (m2_fall & (presc == 2'd3)) : a12_rise;
  assign next_cnt = (counter == 8'd0 || reload) ? irq_latch : counter - 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) r[i] <= rst_vals[i];
      idx <= '0;
      prg_mod <= 1'b0;
      chr_mod <= 1'b0;
      mirroring <= mir_h;
      ram_ce_on <= 1'b0;
      ram_we_off <= 1'b0;
      irq_latch <= 8'd0;
      counter <= 8'd0;
      reload <= 1'b0;
      irq_en <= 1'b0;
      pending <= 1'b0;
      presc <= 2'd0;
      m2_s1 <= 1'b0;
      m2_s2 <= 1'b0;
      a12_s1 <= 1'b0;
      a12_s2 <= 1'b0;
      low_cnt <= LW'(A12_LOW_MIN);
      {cap_ce_n, cap_a14, cap_a13, cap_a0, cap_rw, cap_data} <= {1'b1, 3'b000, 1'b1, 8'd0};
`ifdef MMC3_EXT_EN
      k1 <= 1'b0;
      irq_mode <= 1'b0;
`endif
    end else begin
      m2_s1 <= cpu_m2;
      m2_s2 <= m2_s1;
      a12_s1 <= ppu_addr[2];
      a12_s2 <= a12_s1;
      low_cnt <= a12_s1 ? '0 : (low_cnt == LW'(A12_LOW_MIN) ? low_cnt : low_cnt + 1'b1);
      if (m2_s1) {cap_ce_n, cap_a14, cap_a13, cap_a0, cap_rw, cap_data} <=
                   {cpu_ce_n, cpu_a14, cpu_a13, cpu_a0, cpu_rw, cpu_data};
      if (m2_fall && !wr) presc <= presc + 2'd1;
      if (wr) begin
        case ({cap_a14, cap_a13, cap_a0})
          3'b000: begin
            idx <= cap_data[IW-1:0];
            prg_mod <= cap_data[6];
            chr_mod <= cap_data[7];
`ifdef MMC3_EXT_EN
            k1 <= cap_data[5];
`endif
          end
          3'b001: r[idx] <= cap_data;
          3'b010: mirroring <= cap_data[0];
          3'b011: {ram_ce_on, ram_we_off} <= cap_data[7:6];
          3'b100: irq_latch <= cap_data;
          3'b101: begin
            reload <= 1'b1;
            presc <= 2'd0;
`ifdef MMC3_EXT_EN
            irq_mode <= cap_data[0];
`endif
          end
          3'b110: begin
            irq_en <= 1'b0;
            pending <= 1'b0;
          end
          default: irq_en <= 1'b1;
        endcase
      end else if (clk_ev) begin
        counter <= next_cnt;
        reload <= 1'b0;
        if (next_cnt == 8'd0 && irq_en) pending <= 1'b1;
      end
    end
  end
  assign lo2k = ppu_addr[1] ? r[1] : r[0];
  assign c1k = ppu_addr[1] ? (ppu_addr[0] ? r[5] : r[4]) : (ppu_addr[0] ? r[3] : r[2]);
  assign chr8 = (ppu_addr[2] == chr_mod) ? c2k : c1k;
  assign chr_addr = chr8[CHR_W-1:0];
  assign prg_addr = (cpu_a14 & cpu_a13) ? '1 : cpu_a13 ? r[7][PRG_W-1:0] :
                    (cpu_a14 ^ prg_mod) ? prg_l : r[6][PRG_W-1:0];
  assign ciram_a10 = mirroring ? ppu_addr[1] : ppu_addr[0];
  assign prg_ce_n = ~(~cpu_ce_n & cpu_rw);
  assign ram_ce_n = ~(cpu_ce_n & cpu_a14 & cpu_a13 & ram_ce_on);
  assign ram_we_n = ~(~cpu_rw & ~ram_we_off);
  assign irq_n = ~pending;
endmodule

// File: tb/tb_mmc3_ext_mapper.sv
// tb_mmc3_ext_mapper: directed checks of banking, strobes, A12 filter, IRQ counter and reset
module tb_mmc3_ext_mapper;
  logic clk = 0, rst_n = 1;
  logic [7:0] cpu_data = 0;
  logic cpu_a14 = 0, cpu_a13 = 0, cpu_a0 = 0, cpu_ce_n = 1, cpu_rw = 1, cpu_m2 = 0;
  logic [2:0] ppu_addr = 0;
  logic mir_h = 1;
  logic irq_n, ciram_a10, ram_ce_n, ram_we_n, prg_ce_n;
  logic [5:0] prg_addr;
  logic [7:0] chr_addr;
  int tests = 0, fails = 0;
  mmc3_ext_mapper dut (
    .clk(clk), .rst_n(rst_n), .cpu_data(cpu_data), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
    .cpu_a0(cpu_a0), .cpu_ce_n(cpu_ce_n), .cpu_rw(cpu_rw), .cpu_m2(cpu_m2),
    .ppu_addr(ppu_addr), .mir_h(mir_h), .irq_n(irq_n), .ciram_a10(ciram_a10),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .prg_ce_n(prg_ce_n),
    .prg_addr(prg_addr), .chr_addr(chr_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic a14, input logic a13, input logic a0, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_a14 = a14; cpu_a13 = a13; cpu_a0 = a0; cpu_data = d; cpu_ce_n = 0; cpu_rw = rw; cpu_m2 = 1;
    repeat (4) @(posedge clk);
    #1 cpu_m2 = 0;
    repeat (4) @(posedge clk);
    #1 cpu_ce_n = 1; cpu_rw = 1;
  endtask
  task automatic pins(input logic a14, input logic a13, input logic [2:0] ppu);
    cpu_a14 = a14; cpu_a13 = a13; ppu_addr = ppu;
    #1;
  endtask
  task automatic a12_pulse(input int lo, input int hi);
    @(posedge clk); #1 ppu_addr[2] = 0;
    repeat (lo) @(posedge clk);
    #1 ppu_addr[2] = 1;
    repeat (hi) @(posedge clk);
    #1;
  endtask
  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    pins(0, 0, 3'b000); chk("rst_prg00", prg_addr, 6'h00); chk("rst_chr0000", chr_addr, 8'h00);
    chk("rst_irq_n", irq_n, 1'b1); chk("rst_ram_ce_n", ram_ce_n, 1'b1);
    pins(0, 1, 3'b000); chk("rst_prg01", prg_addr, 6'h01);
    pins(1, 0, 3'b000); chk("rst_prg10", prg_addr, 6'h3e);
    pins(1, 1, 3'b000); chk("rst_prg11", prg_addr, 6'h3f);
    pins(0, 0, 3'b010); chk("rst_ciram_a11_hi", ciram_a10, 1'b1); chk("rst_chr0800", chr_addr, 8'h02);
    pins(0, 0, 3'b001); chk("rst_ciram_a10_only", ciram_a10, 1'b0); chk("rst_chr0400", chr_addr, 8'h01);
    pins(0, 0, 3'b101); chk("rst_chr1400", chr_addr, 8'h05);
    pins(0, 0, 3'b110); chk("rst_chr1800", chr_addr, 8'h06);
    cpu_ce_n = 0; pins(0, 0, 3'b000); chk("prg_ce_read", prg_ce_n, 1'b0);
    cpu_rw = 0; #1 chk("prg_ce_write", prg_ce_n, 1'b1); chk("ram_we_default", ram_we_n, 1'b0);
    cpu_ce_n = 1; cpu_rw = 1;
    pins(1, 1, 3'b000); chk("ram_ce_off", ram_ce_n, 1'b1);
    bus(0, 0, 0, 0, 8'h46);
    bus(0, 0, 1, 0, 8'h05);
    pins(1, 0, 3'b000); chk("prg_r6_at_c000", prg_addr, 6'h05);
    pins(0, 0, 3'b000); chk("prg_l_at_8000", prg_addr, 6'h3e);
    bus(0, 1, 1, 0, 8'h80);
    pins(1, 1, 3'b000); chk("ram_ce_on", ram_ce_n, 1'b0);
    pins(0, 1, 3'b000); chk("ram_ce_a14_low", ram_ce_n, 1'b1);
    bus(0, 1, 1, 0, 8'hc0);
    cpu_rw = 0; #1 chk("ram_we_off", ram_we_n, 1'b1);
    cpu_rw = 1;
    bus(0, 1, 0, 0, 8'h00);
    pins(0, 0, 3'b001); chk("mir_v_a10", ciram_a10, 1'b1);
    pins(0, 0, 3'b010); chk("mir_v_a11", ciram_a10, 1'b0);
    bus(0, 0, 0, 0, 8'h28);
    bus(0, 0, 1, 0, 8'h33);
    pins(0, 0, 3'b001); chk("chr_0400", chr_addr, 8'h33);
`ifdef MMC3_EXT_EN
    pins(0, 0, 3'b000); chk("chr_0000_k1", chr_addr, 8'h00);
`else
    pins(0, 0, 3'b000); chk("chr_0000_2k", chr_addr, 8'h32);
`endif
    pins(0, 0, 3'b011); chk("chr_0c00", chr_addr, 8'h03);
    ppu_addr = 0;
    repeat (20) @(posedge clk);
    bus(1, 0, 0, 0, 8'd2);
    bus(1, 0, 1, 0, 8'd0);
    bus(1, 1, 1, 0, 8'd0);
    a12_pulse(20, 4);
    a12_pulse(20, 4);
    chk("irq_before_3rd", irq_n, 1'b1);
    a12_pulse(20, 1);
    chk("irq_3rd_sync", irq_n, 1'b1);
    @(posedge clk); #1 chk("irq_3rd", irq_n, 1'b0);
    bus(1, 1, 0, 0, 8'd0);
    chk("e000_clear", irq_n, 1'b1);
    bus(1, 0, 0, 0, 8'd0);
    a12_pulse(20, 2);
    bus(1, 1, 1, 0, 8'd0);
    for (int i = 0; i < 3; i++) a12_pulse(8, 4);
    chk("short_low_ignored", irq_n, 1'b1);
    a12_pulse(16, 3);
    chk("low16_counted", irq_n, 1'b0);
    bus(1, 1, 0, 0, 8'd0);
    ppu_addr = 0;
    bus(1, 0, 0, 0, 8'd1);
    bus(1, 0, 1, 0, 8'd1);
    bus(1, 1, 1, 0, 8'd0);
    for (int i = 0; i < 7; i++) bus(0, 0, 0, 1, 8'd0);
    chk("m2_after_7", irq_n, 1'b1);
    bus(0, 0, 0, 1, 8'd0);
`ifdef MMC3_EXT_EN
    chk("m2_after_8", irq_n, 1'b0);
`else
    chk("m2_mode_tied", irq_n, 1'b1);
`endif
    bus(1, 1, 0, 0, 8'd0);
    chk("m2_e000", irq_n, 1'b1);
    bus(1, 0, 1, 0, 8'd0);
    bus(1, 0, 0, 0, 8'd0);
    bus(1, 1, 1, 0, 8'd0);
    a12_pulse(20, 3);
    chk("pre_reset_irq", irq_n, 1'b0);
    mir_h = 0;
    @(posedge clk); #3 rst_n = 0;
    #1 chk("reset_irq_async", irq_n, 1'b1);
    pins(0, 0, 3'b001); chk("reset_prg", prg_addr, 6'h00); chk("reset_chr", chr_addr, 8'h01);
    chk("reset_mir", ciram_a10, 1'b1);
    pins(1, 0, 3'b001); chk("reset_prg_l", prg_addr, 6'h3e);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
